// File: rtl/maze_pkg.sv
// Shared types and helpers for the wall-following maze solver.
package maze_pkg;

  // Headings are kept as a 2-bit compass code so that turns are plain mod-4 adds.
  typedef enum logic [1:0] {N = 2'd0, W = 2'd1, S = 2'd2, E = 2'd3} dir_t;

  typedef enum logic [1:0] {TURN_L = 2'd0, TURN_R = 2'd1, TURN_180 = 2'd2} turn_t;

  // Encoding 2'b11 behaves like left.
  typedef enum logic [1:0] {AFF_L = 2'd0, AFF_R = 2'd1, AFF_ALT = 2'd2, AFF_L2 = 2'd3} aff_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MV_FWD    = 3'd1,
    ST_WAIT_FWD  = 3'd2,
    ST_HDNG      = 3'd3,
    ST_WAIT_HDNG = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Expand a compass code into the signed heading value of width w; callers cast to w bits.
  function automatic logic [31:0] hdng_of(dir_t d, int w);
    case (d)
      N:       return 32'd0;
      W:       return (32'd1 << (w - 2)) - 32'd1;
      S:       return (32'd1 << (w - 1)) - 32'd1;
      default: return 32'd3 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/maze_turn_sel.sv
// Turn selection for one wall-following decision: picks the preferred side for the
// effective affinity, falls back to the other side, else turns around.
module maze_turn_sel
  import maze_pkg::*;
(
  input  logic       i_aff,
  input  logic [1:0] i_aff_code,
  input  logic       i_phase,
  input  logic       i_lft_opn,
  input  logic       i_rght_opn,
  output logic       o_eff_rght,
  output logic [1:0] o_turn
);

  logic w_rght;

  // Resolve effective affinity, then the turn it prefers for the current openings.
  always_comb begin
    w_rght = (i_aff_code == AFF_R) || ((i_aff_code == AFF_ALT) && i_phase);
    o_turn = TURN_180;
    if (w_rght) begin
      if (i_rght_opn)     o_turn = TURN_R;
      else if (i_lft_opn) o_turn = TURN_L;
    end else begin
      if (i_lft_opn)       o_turn = TURN_L;
      else if (i_rght_opn) o_turn = TURN_R;
    end
    o_eff_rght = w_rght & i_aff;
  end

endmodule

// File: rtl/maze_solve_gen.sv
// Wall-following maze solve sequencer: alternates forward moves and heading changes
// until sol_cmplt, with selectable affinity, turn counting and cmd_md abort.
// Optional turn limit abort enabled by defining MAZE_SOLVE_TURN_LIMIT_EN.
module maze_solve_gen
  import maze_pkg::*;
#(
  parameter int HDNG_W     = 12,
  parameter int CNT_W      = 10,
  parameter int TURN_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_md,
  input  logic [1:0]        cmd_aff,
  input  logic              lft_opn,
  input  logic              rght_opn,
  input  logic              mv_cmplt,
  input  logic              sol_cmplt,
  output logic              strt_mv,
  output logic              strt_hdng,
  output logic [HDNG_W-1:0] dsrd_hdng,
  output logic              stp_lft,
  output logic              stp_rght,
  output logic              busy,
  output logic              solved,
  output logic              aborted,
  output logic [CNT_W-1:0]  turn_cnt
);

  state_t           r_state, w_nxt;
  dir_t             r_dir;
  logic             r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_solved;
  logic             r_stp_lft, r_stp_rght;
  logic             w_start, w_turn_en, w_sol, w_at_lim;
  logic             w_eff_rght;
  logic [1:0]       w_turn;
  logic [1:0]       w_delta;

  maze_turn_sel u_turn_sel (
    .i_aff      (1'b1),
    .i_aff_code (cmd_aff),
    .i_phase    (r_phase),
    .i_lft_opn  (lft_opn),
    .i_rght_opn (rght_opn),
    .o_eff_rght (w_eff_rght),
    .o_turn     (w_turn)
  );

`ifdef MAZE_SOLVE_TURN_LIMIT_EN
  logic r_aborted;
  assign w_at_lim = (r_cnt == CNT_W'(TURN_LIMIT));
  assign aborted  = r_aborted;
`else
  logic w_unused_lim;
  assign w_unused_lim = (TURN_LIMIT == 0);
  assign w_at_lim     = 1'b0;
  assign aborted      = 1'b0;
`endif

  // Compass delta for the selected turn: left +1, right -1, around +2 (mod 4).
  always_comb begin
    case (w_turn)
      TURN_L:  w_delta = 2'd1;
      TURN_R:  w_delta = 2'd3;
      default: w_delta = 2'd2;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state and pulses; cmd_md in an active state aborts without a pulse.
  always_comb begin
    w_nxt     = r_state;
    strt_mv   = 1'b0;
    strt_hdng = 1'b0;
    w_start   = 1'b0;
    w_turn_en = 1'b0;
    w_sol     = 1'b0;
    case (r_state)
      ST_IDLE: if (!cmd_md) begin
        w_nxt   = ST_MV_FWD;
        w_start = 1'b1;
      end
      ST_MV_FWD: begin
        if (cmd_md) w_nxt = ST_IDLE;
        else begin
          strt_mv = 1'b1;
          w_nxt   = ST_WAIT_FWD;
        end
      end
      ST_WAIT_FWD: begin
        if (cmd_md) w_nxt = ST_IDLE;
        else if (sol_cmplt) begin
          w_nxt = ST_DONE;
          w_sol = 1'b1;
        end else if (mv_cmplt) begin
          if (w_at_lim) w_nxt = ST_DONE;
          else begin
            w_nxt     = ST_HDNG;
            w_turn_en = 1'b1;
          end
        end
      end
      ST_HDNG: begin
        if (cmd_md) w_nxt = ST_IDLE;
        else begin
          strt_hdng = 1'b1;
          w_nxt     = ST_WAIT_HDNG;
        end
      end
      ST_WAIT_HDNG: begin
        if (cmd_md) w_nxt = ST_IDLE;
        else if (sol_cmplt) begin
          w_nxt = ST_DONE;
          w_sol = 1'b1;
        end else if (mv_cmplt) w_nxt = ST_MV_FWD;
      end
      ST_DONE: if (cmd_md) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Solve datapath: heading, alternation phase, saturating turn count, sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= N;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_solved   <= 1'b0;
      r_stp_lft  <= 1'b0;
      r_stp_rght <= 1'b0;
    end else begin
      r_stp_lft  <= ~w_eff_rght;
      r_stp_rght <= w_eff_rght;
      if (w_start) begin
        r_dir    <= N;
        r_phase  <= 1'b0;
        r_cnt    <= '0;
        r_solved <= 1'b0;
      end
      if (w_turn_en) begin
        r_dir <= dir_t'(r_dir + w_delta);
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        if ((cmd_aff == AFF_ALT) && (w_turn != TURN_180)) r_phase <= ~r_phase;
      end
      if (w_sol) r_solved <= 1'b1;
    end
  end

`ifdef MAZE_SOLVE_TURN_LIMIT_EN
  // Sticky abort when a decision is reached with the turn budget exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_aborted <= 1'b0;
    else if (w_start) r_aborted <= 1'b0;
    else if ((r_state == ST_WAIT_FWD) && !cmd_md && !sol_cmplt && mv_cmplt && w_at_lim)
      r_aborted <= 1'b1;
  end
`endif

  assign dsrd_hdng = HDNG_W'(hdng_of(r_dir, HDNG_W));
  assign stp_lft   = r_stp_lft;
  assign stp_rght  = r_stp_rght;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign solved    = r_solved;
  assign turn_cnt  = r_cnt;

endmodule

// File: tb/tb_maze_solve_gen.sv
// Self-checking bench for maze_solve_gen (default build, turn limit disabled).
module tb_maze_solve_gen;

  localparam int HW = 12;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n, cmd_md, lft_opn, rght_opn, mv_cmplt, sol_cmplt;
  logic [1:0]    cmd_aff;
  logic          strt_mv, strt_hdng, stp_lft, stp_rght, busy, solved, aborted;
  logic [HW-1:0] dsrd_hdng;
  logic [CW-1:0] turn_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // reference state: compass index, alternation phase (1 = right), turn count, affinity
  int m_dir, m_cnt, m_aff;
  bit m_phase;

  maze_solve_gen #(.HDNG_W(HW), .CNT_W(CW), .TURN_LIMIT(1000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .cmd_aff(cmd_aff),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
    .strt_mv(strt_mv), .strt_hdng(strt_hdng), .dsrd_hdng(dsrd_hdng),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .busy(busy), .solved(solved),
    .aborted(aborted), .turn_cnt(turn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Heading value for compass index d: N=0, W=2^(HW-2)-1, S=2^(HW-1)-1, E=3*2^(HW-2).
  function automatic int exp_hdng(input int d);
    case (d)
      0: return 0;
      1: return (1 << (HW - 2)) - 1;
      2: return (1 << (HW - 1)) - 1;
      default: return 3 << (HW - 2);
    endcase
  endfunction

  function automatic bit eff_right();
    return (m_aff == 1) || (m_aff == 2 && m_phase);
  endfunction

  // Apply one wall-following decision to the reference state.
  task automatic model_turn(input bit l, input bit r);
    bit rt; int step;
    rt = eff_right();
    if (rt ? r : l)      step = rt ? 3 : 1;
    else if (rt ? l : r) step = rt ? 1 : 3;
    else                 step = 2;
    m_dir = (m_dir + step) % 4;
    if (m_aff == 2 && step != 2) m_phase = ~m_phase;
    if (m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  // Called at a negedge with the DUT idle and cmd_md=1; leaves us in MV_FWD.
  task automatic start_solve(input int aff);
    m_aff = aff; m_dir = 0; m_cnt = 0; m_phase = 0;
    cmd_aff = 2'(aff);
    cmd_md = 1'b0;
    @(negedge clk);
    chk("start_strt_mv", strt_mv, 1);
    chk("start_busy", busy, 1);
    chk("start_turn_cnt", turn_cnt, 0);
    chk("start_solved", solved, 0);
    chk("start_hdng", dsrd_hdng, 0);
  endtask

  // From MV_FWD: one move + decision. mode 0 continue, 1 cmd_md abort in WAIT_HDNG,
  // 2 sol_cmplt in WAIT_HDNG.
  task automatic decide(input bit l, input bit r, input int mode);
    chk("mv_pulse", strt_mv, 1);
    @(negedge clk);
    chk("wait_fwd_no_mv", strt_mv, 0);
    mv_cmplt = 1'b1; lft_opn = l; rght_opn = r;
    @(negedge clk);
    mv_cmplt = 1'b0;
    model_turn(l, r);
    chk("hdng_pulse", strt_hdng, 1);
    chk("hdng_value", dsrd_hdng, exp_hdng(m_dir));
    chk("turn_cnt", turn_cnt, m_cnt);
    @(negedge clk);
    chk("hdng_pulse_end", strt_hdng, 0);
    chk("stp_lft", stp_lft, !eff_right());
    chk("stp_rght", stp_rght, eff_right());
    if (mode == 1) cmd_md = 1'b1;
    else if (mode == 2) sol_cmplt = 1'b1;
    else mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    if (mode == 1) begin
      chk("abort_busy", busy, 0);
      chk("abort_no_mv", strt_mv, 0);
      chk("abort_hdng_held", dsrd_hdng, exp_hdng(m_dir));
      chk("abort_cnt_held", turn_cnt, m_cnt);
    end else if (mode == 2) begin
      chk("solhd_busy", busy, 0);
      chk("solhd_solved", solved, 1);
      chk("solhd_no_mv", strt_mv, 0);
    end
  endtask

  // From MV_FWD: sol_cmplt and mv_cmplt together in WAIT_FWD; solve wins.
  task automatic end_fwd();
    @(negedge clk);
    sol_cmplt = 1'b1; mv_cmplt = 1'b1; lft_opn = 1'b1; rght_opn = 1'b1;
    @(negedge clk);
    sol_cmplt = 1'b0; mv_cmplt = 1'b0;
    chk("solfw_busy", busy, 0);
    chk("solfw_solved", solved, 1);
    chk("solfw_no_hdng", strt_hdng, 0);
    chk("solfw_cnt", turn_cnt, m_cnt);
    chk("solfw_hdng", dsrd_hdng, exp_hdng(m_dir));
    @(negedge clk);
    chk("done_hold_hdng", strt_hdng, 0);
    chk("done_hold_mv", strt_mv, 0);
  endtask

  // From DONE: return to IDLE with flags held.
  task automatic leave_done();
    cmd_md = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_solved_held", solved, 1);
    chk("idle_aborted", aborted, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_md = 1'b1; cmd_aff = 2'd0; lft_opn = 1'b0; rght_opn = 1'b0;
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    @(negedge clk);
    chk("rst_strt_mv", strt_mv, 0);
    chk("rst_strt_hdng", strt_hdng, 0);
    chk("rst_hdng", dsrd_hdng, 0);
    chk("rst_stp_lft", stp_lft, 0);
    chk("rst_stp_rght", stp_rght, 0);
    chk("rst_busy", busy, 0);
    chk("rst_solved", solved, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_turn_cnt", turn_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("onehot_lft", stp_lft, 1);
    chk("onehot_rght", stp_rght, 0);
    chk("idle_hold", busy, 0);

    // left affinity: left turn, then dead end from W, then simultaneous sol/mv
    start_solve(0);
    decide(1'b1, 1'b0, 0);
    decide(1'b0, 1'b0, 0);
    end_fwd();
    leave_done();

    // right affinity: four right turns wrap the heading, then abort in WAIT_HDNG
    start_solve(1);
    for (int i = 0; i < 4; i++) decide(1'b0, 1'b1, 0);
    decide(1'b1, 1'b0, 1);

    // alternating: L then R with both open, then a dead end keeps the phase
    start_solve(2);
    decide(1'b1, 1'b1, 0);
    decide(1'b1, 1'b1, 0);
    decide(1'b0, 1'b0, 0);
    decide(1'b1, 1'b1, 0);
    // reset mid-solve
    rst_n = 1'b0; cmd_md = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_mv", strt_mv, 0);
    chk("mrst_hdng", dsrd_hdng, 0);
    chk("mrst_cnt", turn_cnt, 0);
    chk("mrst_stp", {stp_lft, stp_rght}, 0);
    chk("mrst_solved", solved, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized solves against the reference model
    for (int s = 0; s < 8; s++) begin
      int nd;
      start_solve(int'($urandom_range(3, 0)));
      nd = int'($urandom_range(8, 1));
      for (int d = 0; d < nd; d++)
        decide(1'($urandom), 1'($urandom), (d == nd - 1 && s[0]) ? 2 : 0);
      if (!s[0]) end_fwd();
      leave_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
